// File: rtl/lcd_bus_arbiter.sv
// Character-LCD bus owner: runs the power-up init sequence, then round-robin shares
// the write-only bus between two byte-write clients with proper E strobe timing.
module lcd_bus_arbiter #(
  parameter int unsigned INIT_WAIT = 70,
  parameter int unsigned E_SETUP   = 2,
  parameter int unsigned E_HIGH    = 8,
  parameter int unsigned CMD_WAIT  = 20,
  parameter int unsigned CLR_WAIT  = 200
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       REQ0,
  input  logic       RS0,
  input  logic [7:0] DATA0,
  output logic       ACK0,
  input  logic       REQ1,
  input  logic       RS1,
  input  logic [7:0] DATA1,
  output logic       ACK1,
  output logic       READY,
  output logic       BUSY,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic [7:0] LCD_DATA
);

  typedef enum logic [2:0] {
    StPowerup,
    StSetup,
    StStrobe,
    StWait,
    StIdle
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  init_idx_q, init_idx_d;
  logic        ready_q, ready_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic        clr_q, clr_d;
  logic        e_q, e_d;
  logic        rs_q, rs_d;
  logic [7:0]  data_q, data_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;

  logic [15:0] wait_last;
  logic        req0_v, req1_v, grant1;

  function automatic logic [7:0] init_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    init_byte = 8'h3C;
      2'd1:    init_byte = 8'h0C;
      2'd2:    init_byte = 8'h06;
      default: init_byte = 8'h01;
    endcase
  endfunction

  assign wait_last = clr_q ? 16'(CLR_WAIT - 1) : 16'(CMD_WAIT - 1);

  // A client's REQ is ignored in its own ACK cycle so a held level is not seen twice.
  assign req0_v = REQ0 & ~ack0_q & ready_q;
  assign req1_v = REQ1 & ~ack1_q & ready_q;
  assign grant1 = req1_v & (~req0_v | ~last_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 16'd1;
    init_idx_d = init_idx_q;
    ready_d    = ready_q;
    owner_d    = owner_q;
    last_d     = last_q;
    clr_d      = clr_q;
    e_d        = e_q;
    rs_d       = rs_q;
    data_d     = data_q;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;

    unique case (state_q)
      StPowerup: begin
        if (cnt_q == 16'(INIT_WAIT - 1)) begin
          state_d    = StSetup;
          cnt_d      = '0;
          init_idx_d = 2'd0;
          rs_d       = 1'b0;
          data_d     = init_byte(2'd0);
        end
      end
      StSetup: begin
        if (cnt_q == 16'(E_SETUP - 1)) begin
          state_d = StStrobe;
          cnt_d   = '0;
          e_d     = 1'b1;
        end
      end
      StStrobe: begin
        if (cnt_q == 16'(E_HIGH - 1)) begin
          state_d = StWait;
          cnt_d   = '0;
          e_d     = 1'b0;
          // Clear display and return home need the long post-command wait.
          clr_d   = ~rs_q & ((data_q == 8'h01) | (data_q == 8'h02));
        end
      end
      StWait: begin
        if (cnt_q == wait_last) begin
          cnt_d = '0;
          if (!ready_q) begin
            if (init_idx_q == 2'd3) begin
              state_d = StIdle;
              ready_d = 1'b1;
            end else begin
              state_d    = StSetup;
              init_idx_d = init_idx_q + 2'd1;
              rs_d       = 1'b0;
              data_d     = init_byte(init_idx_q + 2'd1);
            end
          end else begin
            state_d = StIdle;
            ack0_d  = ~owner_q;
            ack1_d  = owner_q;
          end
        end
      end
      StIdle: begin
        cnt_d = '0;
        if (req0_v | req1_v) begin
          state_d = StSetup;
          owner_d = grant1;
          last_d  = grant1;
          rs_d    = grant1 ? RS1 : RS0;
          data_d  = grant1 ? DATA1 : DATA0;
        end
      end
      default: begin
        state_d = StPowerup;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state_q    <= StPowerup;
      cnt_q      <= '0;
      init_idx_q <= 2'd0;
      ready_q    <= 1'b0;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      clr_q      <= 1'b0;
      e_q        <= 1'b0;
      rs_q       <= 1'b0;
      data_q     <= 8'h00;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      init_idx_q <= init_idx_d;
      ready_q    <= ready_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      clr_q      <= clr_d;
      e_q        <= e_d;
      rs_q       <= rs_d;
      data_q     <= data_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
    end
  end

  assign ACK0     = ack0_q;
  assign ACK1     = ack1_q;
  assign READY    = ready_q;
  assign BUSY     = (state_q != StIdle);
  assign LCD_E    = e_q;
  assign LCD_RS   = rs_q;
  assign LCD_RW   = 1'b0;
  assign LCD_DATA = data_q;

endmodule

// File: doc/lcd_bus_arbiter.md
Name: lcd_bus_arbiter

Overview:
- Owns the character-LCD bus (LCD_E/RS/RW/DATA, write-only) and performs the power-up init sequence.
- Then shares the bus between two byte-write clients using round-robin arbitration.
- Generates a real E strobe with setup, high and post-command wait timing, so clients such as the time-of-day line writer and the alarm/status line writer never drive the LCD directly.

Parameters:
INIT_WAIT, 70, cycles from reset release before the first init command
E_SETUP, 2, cycles RS/DATA are stable before E rises
E_HIGH, 8, cycles E is held high
CMD_WAIT, 20, post-strobe wait for normal commands and data
CLR_WAIT, 200, post-strobe wait when RS=0 and DATA is 0x01 or 0x02

Ports:
CLK  in  1  system clock
RESETN  in  1  reset, synchronous, active-low
REQ0  in  1  client 0 write request; level, held until ACK0
RS0  in  1  client 0 register select (0=command, 1=data)
DATA0  in  8  client 0 byte
ACK0  out  1  one-cycle pulse when client 0's write completes
REQ1  in  1  client 1 write request
RS1  in  1  client 1 register select
DATA1  in  8  client 1 byte
ACK1  out  1  client 1 completion pulse
READY  out  1  high once the init sequence has finished
BUSY  out  1  high whenever the FSM is not in IDLE
LCD_E  out  1  LCD enable strobe
LCD_RS  out  1  LCD register select
LCD_RW  out  1  LCD read/write; always 0
LCD_DATA  out  8  LCD data bus

Behaviour:
- Reset values: LCD_E=0, LCD_RS=0, LCD_RW=0, LCD_DATA=0x00, ACK0=ACK1=0, READY=0, BUSY=1, RR pointer=1 (client 0 wins first).
- Reset mid-operation: the transaction is abandoned, no ACK, READY drops and the init sequence restarts.
- States:
  - POWERUP: counts INIT_WAIT cycles, then enters SETUP with the first init byte.
  - SETUP: E=0, bus driven for E_SETUP cycles.
  - STROBE: E=1 for E_HIGH cycles.
  - WAIT: E=0, bus held for CMD_WAIT or CLR_WAIT cycles.
  - IDLE.
- Init bytes, all RS=0: 0x3C, 0x0C, 0x06, 0x01, in that order. Each runs SETUP→STROBE→WAIT with no client ACK.
- READY rises at the edge the final 0x01 wait completes, entering IDLE. READY stays 1 until reset.
- IDLE, READY=1: arbitration happens at the sampling edge k.
  - If one REQ is high, that client is granted.
  - If both are high, the client not granted last is granted. The RR pointer updates at grant.
  - At edge k, RS/DATA of the granted client are latched onto LCD_RS/LCD_DATA. Later changes on the client inputs are ignored.
- Timing from grant edge k: LCD_E rises at k+E_SETUP and falls at k+E_SETUP+E_HIGH. ACKn is high for the cycle after edge k+E_SETUP+E_HIGH+W, where W is CMD_WAIT or CLR_WAIT. The FSM is back in IDLE at that same edge.
- Defaults: ACK at k+30 for normal writes, k+210 for clear/home.
- Next grant no earlier than the edge after the ACK edge. A client's REQ that is still high in the ACK cycle is not re-sampled as a new request.
- REQ deasserted after grant: the write still completes and ACK still pulses.
- REQ while READY=0: not granted, no ACK; serviced once READY=1.
- IDLE: E=0, LCD_RS/LCD_DATA hold the last value. LCD_RW is 0 in every state.
- Counter: one shared cycle counter of at least 16 bits, cleared on each state change. All waits are exact cycle counts, with no off-by-one relative to the parameter.
- ACK0 and ACK1 are never high in the same cycle.

Test Plan:
- Release reset, no requests: exactly 4 E pulses, bytes 0x3C, 0x0C, 0x06, 0x01 with RS=0. First E rise at edge 72. Each pulse is 8 cycles wide. READY rises 200 cycles after the 4th E falls. No ACKs.
- After READY, REQ0 with RS0=1, DATA0=0x35 granted at edge k: LCD_DATA=0x35 and RS=1 from k, E high k+2..k+10, ACK0 pulses once at k+30, ACK1 stays 0. Changing DATA0 to 0x00 at k+1 leaves LCD_DATA=0x35.
- REQ0 and REQ1 both held high continuously: grants alternate 0,1,0,1 starting with client 0. ACKs are 31 cycles apart, one ACK per transaction, never coincident.
- Client 1 writes RS=0 0x01: ACK1 at k+210. Client 1 writes RS=0 0x80: ACK1 at k+30. Client 1 writes RS=1 0x01 (data byte): ACK1 at k+30.
- REQ1 asserted during init: no E pulse beyond the 4 init pulses and no ACK1 until READY=1. First post-init grant goes to client 1 with its byte.
- RESETN low during STROBE of a client write: at the next edge E=0, READY=0, no ACK. After release, the full init sequence repeats with the same timing as the first scenario.
